// File: rtl/jedro_1_sign_extender.sv
// Registered immediate sign/zero extender for the jedro_1 decode stage.
// Define SIGNEXT_COMB_OUT_EN to also expose the combinational result on out_o.
module jedro_1_sign_extender #(
    parameter int N = 32,
    parameter int M = 12,
    localparam int LW = $clog2(M + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          valid_i,
    input  logic [M-1:0]  in_i,
    input  logic [LW-1:0] len_i,
    input  logic          zero_ext_i,
    output logic [N-1:0]  out_q_o,
    output logic          valid_o,
    output logic          neg_o
`ifdef SIGNEXT_COMB_OUT_EN
    ,
    output logic [N-1:0]  out_o
`endif
);

    generate
        if (M > N || M < 1) begin : g_bad_params
            $error("jedro_1_sign_extender: requires 1 <= M <= N");
        end
    endgenerate

    int unsigned len_val;
    int unsigned eff_len;
    logic        fill_bit;
    logic [N-1:0] result;

    // Zero or out-of-range length selects the full field; bits at or above
    // the effective length are dropped and replaced by the fill bit.
    always_comb begin
        len_val  = 32'(len_i);
        eff_len  = (len_val == 0 || len_val > M) ? M : len_val;
        fill_bit = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (!zero_ext_i && (i == int'(eff_len) - 1)) begin
                fill_bit = in_i[i];
            end
        end
        result = {N{fill_bit}};
        for (int i = 0; i < M; i++) begin
            if (i < int'(eff_len)) begin
                result[i] = in_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_q_o <= '0;
            neg_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                out_q_o <= result;
                neg_o   <= result[N-1];
            end
        end
    end

`ifdef SIGNEXT_COMB_OUT_EN
    assign out_o = result;
`endif

endmodule

// File: tb/tb_jedro_1_sign_extender.sv
// Directed-vector bench for jedro_1_sign_extender (N=32, M=12).
module tb_jedro_1_sign_extender;

    logic        clk_i;
    logic        rstn_i;
    logic        valid_i;
    logic [11:0] in_i;
    logic [3:0]  len_i;
    logic        zero_ext_i;
    logic [31:0] out_q_o;
    logic        valid_o;
    logic        neg_o;
`ifdef SIGNEXT_COMB_OUT_EN
    logic [31:0] out_o;
`endif

    int checkCount = 0;
    int passCount  = 0;

    jedro_1_sign_extender #(.N(32), .M(12)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .valid_i    (valid_i),
        .in_i       (in_i),
        .len_i      (len_i),
        .zero_ext_i (zero_ext_i),
        .out_q_o    (out_q_o),
        .valid_o    (valid_o),
        .neg_o      (neg_o)
`ifdef SIGNEXT_COMB_OUT_EN
        ,
        .out_o      (out_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational result when present,
    // then step past the rising edge so registered outputs can be sampled.
    task automatic applyStimulus(input logic rstn, input logic v, input logic [11:0] din,
                                 input logic [3:0] len, input logic zext,
                                 input logic [31:0] expComb);
        @(negedge clk_i);
        rstn_i     = rstn;
        valid_i    = v;
        in_i       = din;
        len_i      = len;
        zero_ext_i = zext;
        #1;
`ifdef SIGNEXT_COMB_OUT_EN
        checkOutput("comb_out", out_o, expComb);
`else
        if (expComb === 32'hxxxx_xxxx) $display("[TB] unexpected X expectation");
`endif
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic [31:0] expOut,
                             input logic expValid, input logic expNeg);
        checkOutput({tag, "_out"}, out_q_o, expOut);
        checkOutput({tag, "_valid"}, {31'b0, valid_o}, {31'b0, expValid});
        checkOutput({tag, "_neg"}, {31'b0, neg_o}, {31'b0, expNeg});
    endtask

    initial begin
        rstn_i     = 1'b0;
        valid_i    = 1'b1;
        in_i       = 12'hFFF;
        len_i      = 4'd0;
        zero_ext_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkRegs("reset", 32'h0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 12'h800, 4'd0, 1'b0, 32'hFFFF_F800);
        checkRegs("sext_neg", 32'hFFFF_F800, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 12'h7FF, 4'd0, 1'b0, 32'h0000_07FF);
        checkRegs("sext_pos", 32'h0000_07FF, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 12'h800, 4'd0, 1'b1, 32'h0000_0800);
        checkRegs("zext", 32'h0000_0800, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 12'hFF0, 4'd5, 1'b0, 32'hFFFF_FFF0);
        checkRegs("len5", 32'hFFFF_FFF0, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 12'hFF0, 4'd4, 1'b0, 32'h0000_0000);
        checkRegs("len4", 32'h0000_0000, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 12'hFF0, 4'd15, 1'b0, 32'hFFFF_FFF0);
        checkRegs("len15", 32'hFFFF_FFF0, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 12'hFF0, 4'd5, 1'b1, 32'h0000_0010);
        checkRegs("len5_zext", 32'h0000_0010, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 12'h0F5, 4'd3, 1'b0, 32'hFFFF_FFFD);
        checkRegs("len3_sext", 32'hFFFF_FFFD, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 12'hABC, 4'd12, 1'b0, 32'hFFFF_FABC);
        checkRegs("len12", 32'hFFFF_FABC, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b0, 12'h001, 4'd0, 1'b0, 32'h0000_0001);
        checkRegs("hold_neg", 32'hFFFF_FABC, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 12'h001, 4'd0, 1'b0, 32'h0000_0001);
        checkRegs("b2b_1", 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 12'h002, 4'd0, 1'b0, 32'h0000_0002);
        checkRegs("b2b_2", 32'h0000_0002, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hABC, 4'd0, 1'b0, 32'hFFFF_FABC);
        checkRegs("hold_1", 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'h800, 4'd0, 1'b0, 32'hFFFF_F800);
        checkRegs("hold_2", 32'h0000_0002, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 12'h123, 4'd0, 1'b0, 32'h0000_0123);
        checkRegs("rst_mid", 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 12'h456, 4'd0, 1'b0, 32'h0000_0456);
        checkRegs("after_rst", 32'h0000_0456, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/jedro_1_sign_extender.md
Name: jedro_1_sign_extender

Overview:
Clocked immediate extender for the jedro_1 RV32I core. It widens an M-bit immediate field to N bits by sign or zero extension. The source field length can be narrowed at run time. The result is registered with a one-cycle valid pipeline for the decode stage, and an optional combinational copy is provided for same-cycle use by the decoder.

Parameters:
- N, 32, output width in bits; must satisfy N >= M.
- M, 12, maximum input field width in bits; must satisfy M >= 1.
- LW, $clog2(M+1), derived localparam giving the width of len_i; not user-overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  synchronous, active-low reset.
- valid_i  input  1  qualifies in_i, len_i and zero_ext_i this cycle.
- in_i  input  M  raw immediate field; bit 0 is the LSB.
- len_i  input  LW  effective field length in bits; 0 means M.
- zero_ext_i  input  1  1 = zero-extend, 0 = sign-extend.
- out_q_o  output  N  registered extended result.
- valid_o  output  1  out_q_o was updated on the last edge.
- neg_o  output  1  registered MSB of the result (result[N-1]).
- out_o  output  N  combinational result; exists only with SIGNEXT_COMB_OUT_EN.

Behaviour:
- Effective length: E = M when len_i == 0 or len_i > M; otherwise E = len_i.
- Combinational result R:
  - R[E-1:0] = in_i[E-1:0].
  - R[N-1:E] = all copies of in_i[E-1] when zero_ext_i = 0, or all zeros when zero_ext_i = 1.
- in_i bits at positions >= E are ignored and never reach R.
- When E == N (only possible with M == N), R = in_i unchanged.
- Reset (rstn_i = 0 at a rising edge): out_q_o = 0, valid_o = 0, neg_o = 0. Reset has priority over valid_i.
- Normal edge with valid_i = 1: out_q_o <= R, neg_o <= R[N-1], valid_o <= 1. Latency is exactly 1 cycle.
- Normal edge with valid_i = 0: valid_o <= 0; out_q_o and neg_o hold their previous values.
- Back-to-back valid_i: one result per cycle, no bubbles. There is no backpressure.
- Reset mid-stream: an item presented in the same cycle as reset is dropped. The first item after reset deasserts appears one cycle later.
- No internal state other than out_q_o, valid_o and neg_o. X on in_i is allowed only while valid_i = 0.
- Elaboration must fail (generate-time error) if M > N or M < 1.

Optional Feature:
- Macro: SIGNEXT_COMB_OUT_EN.
- Defined: port out_o exists and equals R every cycle, independent of valid_i, clock and reset.
- Not defined: out_o and its logic are absent; only the registered outputs exist.
- Registered behaviour is identical in both builds.

Test Plan (N=32, M=12, LW=4):
- Reset: hold rstn_i = 0 for 2 cycles with valid_i = 1 and in_i = 0xFFF -> out_q_o = 0x00000000, valid_o = 0, neg_o = 0.
- Sign-extend negative: in_i = 0x800, len_i = 0, zero_ext_i = 0, valid_i = 1 -> next cycle out_q_o = 0xFFFFF800, valid_o = 1, neg_o = 1. With the macro, out_o = 0xFFFFF800 in the same cycle.
- Positive and zero-extend:
  - in_i = 0x7FF, sign-extend -> out_q_o = 0x000007FF, neg_o = 0.
  - in_i = 0x800, zero_ext_i = 1 -> out_q_o = 0x00000800, neg_o = 0.
- Narrow length: in_i = 0xFF0, len_i = 5, sign-extend -> out_q_o = 0xFFFFFFF0.
  - Same input with len_i = 4 -> out_q_o = 0x00000000.
  - Same input with len_i = 15 -> E = 12, out_q_o = 0xFFFFFFF0.
- Hold and back-to-back:
  - valid_i pattern 1,1,0,0 with in_i = 0x001 then 0x002 -> out_q_o = 0x1, then 0x2, then holds 0x2.
  - valid_o pattern is 1,1,0,0.
- Reset mid-stream: valid_i = 1, in_i = 0x123 in the cycle rstn_i = 0 -> outputs all 0.
  - Next valid item 0x456 after release -> out_q_o = 0x00000456 one cycle later.
